// File: rtl/algo_2rw_a56_tbl_init.sv
// Init sequencer for the 2rw_a56 map table (t2) and cache table (t3).
// After reset or an accepted reinit it writes the init value into every
// row of both tables through both write ports, waits out the SRAM
// write-to-read latency, then raises ready and hands the ports to the core.
module algo_2rw_a56_tbl_init #(
  parameter int                     NUMVROW     = 2048,
  parameter int                     BITVROW     = 11,
  parameter int                     SDOUT_WIDTH = 10,
  parameter int                     CDOUT_WIDTH = 71,
  parameter int                     SRAM_DELAY  = 2,
  parameter logic [SDOUT_WIDTH-1:0] T2_INITVAL  = '0,
  parameter logic [CDOUT_WIDTH-1:0] T3_INITVAL  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reinit,
  // core side, t2
  input  logic [1:0]               core_t2_writeA,
  input  logic [2*BITVROW-1:0]     core_t2_addrA,
  input  logic [2*SDOUT_WIDTH-1:0] core_t2_dinA,
  input  logic [2*SDOUT_WIDTH-1:0] core_t2_bwA,
  input  logic [1:0]               core_t2_readB,
  input  logic [2*BITVROW-1:0]     core_t2_addrB,
  // core side, t3
  input  logic [1:0]               core_t3_writeA,
  input  logic [2*BITVROW-1:0]     core_t3_addrA,
  input  logic [2*CDOUT_WIDTH-1:0] core_t3_dinA,
  input  logic [2*CDOUT_WIDTH-1:0] core_t3_bwA,
  input  logic [1:0]               core_t3_readB,
  input  logic [2*BITVROW-1:0]     core_t3_addrB,
  // SRAM side, t2
  output logic [1:0]               t2_writeA,
  output logic [2*BITVROW-1:0]     t2_addrA,
  output logic [2*SDOUT_WIDTH-1:0] t2_dinA,
  output logic [2*SDOUT_WIDTH-1:0] t2_bwA,
  output logic [1:0]               t2_readB,
  output logic [2*BITVROW-1:0]     t2_addrB,
  // SRAM side, t3
  output logic [1:0]               t3_writeA,
  output logic [2*BITVROW-1:0]     t3_addrA,
  output logic [2*CDOUT_WIDTH-1:0] t3_dinA,
  output logic [2*CDOUT_WIDTH-1:0] t3_bwA,
  output logic [1:0]               t3_readB,
  output logic [2*BITVROW-1:0]     t3_addrB,
  // status
  output logic                     ready,
  output logic                     init_err
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RDY   = 2'd2
  } state_t;

  // Drain counter must hold SRAM_DELAY; keep at least one bit when it is 0.
  localparam int DCW       = (SRAM_DELAY > 0) ? $clog2(SRAM_DELAY + 1) : 1;
  // Index of the row pair that contains row NUMVROW-1.
  localparam int LAST_PAIR = (NUMVROW - 1) / 2;

  state_t                  state_q, state_d;
  logic [BITVROW-1:0]      row_cnt_q, row_cnt_d;
  logic [DCW-1:0]          drain_cnt_q, drain_cnt_d;
  logic                    ready_q, ready_d;
  logic                    init_err_q, init_err_d;
  // One write-enable/address set drives both tables: t2 and t3 are
  // initialised row-for-row in lockstep.
  logic [1:0]              init_wr_q, init_wr_d;
  logic [2*BITVROW-1:0]    init_addr_q, init_addr_d;

  logic [BITVROW:0]        row1_w;
  logic                    port1_ok;
  logic                    last_pair;
  logic                    core_access;

  // Odd row of the current pair; one extra bit so NUMVROW itself is representable.
  assign row1_w      = {row_cnt_q, 1'b1};
  assign port1_ok    = (row1_w < (BITVROW + 1)'(NUMVROW));
  assign last_pair   = (row_cnt_q == BITVROW'(LAST_PAIR));
  assign core_access = (|core_t2_writeA) | (|core_t2_readB) |
                       (|core_t3_writeA) | (|core_t3_readB);

  // State, counters, init write registers and status flags.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      row_cnt_q   <= '0;
      drain_cnt_q <= '0;
      ready_q     <= 1'b0;
      init_err_q  <= 1'b0;
      init_wr_q   <= '0;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      ready_q     <= ready_d;
      init_err_q  <= init_err_d;
      init_wr_q   <= init_wr_d;
      init_addr_q <= init_addr_d;
    end
  end

  // Next-state logic: walk row pairs, drain the SRAM latency, then hold ready.
  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    drain_cnt_d = drain_cnt_q;
    ready_d     = ready_q;
    init_wr_d   = 2'b00;
    init_addr_d = init_addr_q;
    // Any core access while the tables are not yet valid is a sticky error.
    init_err_d  = init_err_q | (~ready_q & core_access);

    unique case (state_q)
      ST_INIT: begin
        ready_d     = 1'b0;
        init_wr_d   = {port1_ok, 1'b1};
        init_addr_d = {BITVROW'(row1_w), BITVROW'({row_cnt_q, 1'b0})};
        if (last_pair) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DCW'(SRAM_DELAY);
        end else begin
          row_cnt_d = row_cnt_q + 1'b1;
        end
      end

      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = ST_RDY;
          ready_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end

      ST_RDY: begin
        ready_d = 1'b1;
        // Only honoured here; a reinit during INIT/DRAIN falls through untouched.
        if (reinit) begin
          state_d    = ST_INIT;
          row_cnt_d  = '0;
          ready_d    = 1'b0;
          init_err_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_INIT;
        ready_d = 1'b0;
      end
    endcase
  end

  // Port mux: core passes straight through once ready, sequencer owns writes before.
  // Read addresses always follow the core so a read issued at the handover
  // edge already points at the right row.
  always_comb begin
    t2_writeA = core_t2_writeA;
    t2_addrA  = core_t2_addrA;
    t2_dinA   = core_t2_dinA;
    t2_bwA    = core_t2_bwA;
    t2_readB  = core_t2_readB;
    t2_addrB  = core_t2_addrB;
    t3_writeA = core_t3_writeA;
    t3_addrA  = core_t3_addrA;
    t3_dinA   = core_t3_dinA;
    t3_bwA    = core_t3_bwA;
    t3_readB  = core_t3_readB;
    t3_addrB  = core_t3_addrB;
    if (!ready_q) begin
      t2_writeA = init_wr_q;
      t2_addrA  = init_addr_q;
      t2_dinA   = {2{T2_INITVAL}};
      t2_bwA    = '1;
      t2_readB  = 2'b00;
      t3_writeA = init_wr_q;
      t3_addrA  = init_addr_q;
      t3_dinA   = {2{T3_INITVAL}};
      t3_bwA    = '1;
      t3_readB  = 2'b00;
    end
  end

  assign ready    = ready_q;
  assign init_err = init_err_q;

endmodule

// File: tb/tb_algo_2rw_a56_tbl_init.sv
// Bench for algo_2rw_a56_tbl_init: an even-row (8) and an odd-row (7)
// instance share the core-side stimulus. A model tracks, per instance, how
// many edges have passed since the sequence (re)started and derives every
// expected output from that count; directed literal checks pin the model.
module tb_algo_2rw_a56_tbl_init;

  localparam int BV = 3;
  localparam int SW = 10;
  localparam int CW = 71;
  localparam int SD = 2;
  localparam logic [SW-1:0] T2V = 10'h2A5;
  localparam logic [CW-1:0] T3V = 71'h5A_1234_5678_9ABC_DEF0;

  logic clk = 1'b0;
  logic rst;
  logic reinit;

  logic [1:0]      core_t2_writeA, core_t2_readB, core_t3_writeA, core_t3_readB;
  logic [2*BV-1:0] core_t2_addrA, core_t2_addrB, core_t3_addrA, core_t3_addrB;
  logic [2*SW-1:0] core_t2_dinA, core_t2_bwA;
  logic [2*CW-1:0] core_t3_dinA, core_t3_bwA;

  logic [1:0]      a_t2_wa, a_t2_rb, a_t3_wa, a_t3_rb;
  logic [2*BV-1:0] a_t2_aa, a_t2_ab, a_t3_aa, a_t3_ab;
  logic [2*SW-1:0] a_t2_da, a_t2_bw;
  logic [2*CW-1:0] a_t3_da, a_t3_bw;
  logic            a_ready, a_err;

  logic [1:0]      b_t2_wa, b_t2_rb, b_t3_wa, b_t3_rb;
  logic [2*BV-1:0] b_t2_aa, b_t2_ab, b_t3_aa, b_t3_ab;
  logic [2*SW-1:0] b_t2_da, b_t2_bw;
  logic [2*CW-1:0] b_t3_da, b_t3_bw;
  logic            b_ready, b_err;

  int n_checks = 0;
  int n_errs   = 0;

  // model state: edges since (re)start, sticky error flag
  int k8 = 0, k7 = 0;
  bit e8 = 1'b0, e7 = 1'b0;

  always #5 clk = ~clk;

  algo_2rw_a56_tbl_init #(
    .NUMVROW(8), .BITVROW(BV), .SDOUT_WIDTH(SW), .CDOUT_WIDTH(CW),
    .SRAM_DELAY(SD), .T2_INITVAL(T2V), .T3_INITVAL(T3V)
  ) dut8 (
    .clk(clk), .rst(rst), .reinit(reinit),
    .core_t2_writeA(core_t2_writeA), .core_t2_addrA(core_t2_addrA),
    .core_t2_dinA(core_t2_dinA), .core_t2_bwA(core_t2_bwA),
    .core_t2_readB(core_t2_readB), .core_t2_addrB(core_t2_addrB),
    .core_t3_writeA(core_t3_writeA), .core_t3_addrA(core_t3_addrA),
    .core_t3_dinA(core_t3_dinA), .core_t3_bwA(core_t3_bwA),
    .core_t3_readB(core_t3_readB), .core_t3_addrB(core_t3_addrB),
    .t2_writeA(a_t2_wa), .t2_addrA(a_t2_aa), .t2_dinA(a_t2_da), .t2_bwA(a_t2_bw),
    .t2_readB(a_t2_rb), .t2_addrB(a_t2_ab),
    .t3_writeA(a_t3_wa), .t3_addrA(a_t3_aa), .t3_dinA(a_t3_da), .t3_bwA(a_t3_bw),
    .t3_readB(a_t3_rb), .t3_addrB(a_t3_ab),
    .ready(a_ready), .init_err(a_err)
  );

  algo_2rw_a56_tbl_init #(
    .NUMVROW(7), .BITVROW(BV), .SDOUT_WIDTH(SW), .CDOUT_WIDTH(CW),
    .SRAM_DELAY(SD), .T2_INITVAL(T2V), .T3_INITVAL(T3V)
  ) dut7 (
    .clk(clk), .rst(rst), .reinit(reinit),
    .core_t2_writeA(core_t2_writeA), .core_t2_addrA(core_t2_addrA),
    .core_t2_dinA(core_t2_dinA), .core_t2_bwA(core_t2_bwA),
    .core_t2_readB(core_t2_readB), .core_t2_addrB(core_t2_addrB),
    .core_t3_writeA(core_t3_writeA), .core_t3_addrA(core_t3_addrA),
    .core_t3_dinA(core_t3_dinA), .core_t3_bwA(core_t3_bwA),
    .core_t3_readB(core_t3_readB), .core_t3_addrB(core_t3_addrB),
    .t2_writeA(b_t2_wa), .t2_addrA(b_t2_aa), .t2_dinA(b_t2_da), .t2_bwA(b_t2_bw),
    .t2_readB(b_t2_rb), .t2_addrB(b_t2_ab),
    .t3_writeA(b_t3_wa), .t3_addrA(b_t3_aa), .t3_dinA(b_t3_da), .t3_bwA(b_t3_bw),
    .t3_readB(b_t3_rb), .t3_addrB(b_t3_ab),
    .ready(b_ready), .init_err(b_err)
  );

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Ready once all row pairs are written and the SRAM latency has elapsed.
  function automatic bit m_rdy(input int n, input int k);
    return k >= (n + 1) / 2 + SD + 1;
  endfunction

  function automatic bit core_acc();
    return (|core_t2_writeA) | (|core_t2_readB) | (|core_t3_writeA) | (|core_t3_readB);
  endfunction

  // Model advance for one edge, using the inputs present at that edge.
  task automatic m_step(input int n, inout int k, inout bit e);
    bit r;
    r = m_rdy(n, k);
    if (!r && core_acc()) e = 1'b1;
    if (r && reinit) begin
      k = 0;
      e = 1'b0;
    end else if (!r) begin
      k++;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k8 = 0; k7 = 0; e8 = 1'b0; e7 = 1'b0;
    end else begin
      m_step(8, k8, e8);
      m_step(7, k7, e7);
    end
  end

  task automatic cmp_inst(
    input string nm, input int n, input int k, input bit e,
    input logic [1:0] t2_wa, input logic [2*BV-1:0] t2_aa,
    input logic [2*SW-1:0] t2_da, input logic [2*SW-1:0] t2_bw,
    input logic [1:0] t2_rb, input logic [2*BV-1:0] t2_ab,
    input logic [1:0] t3_wa, input logic [2*BV-1:0] t3_aa,
    input logic [2*CW-1:0] t3_da, input logic [2*CW-1:0] t3_bw,
    input logic [1:0] t3_rb, input logic [2*BV-1:0] t3_ab,
    input logic rdy, input logic err);
    bit r;
    r = m_rdy(n, k);
    check({nm, ".ready"}, 256'(rdy), 256'(r));
    check({nm, ".init_err"}, 256'(err), 256'(e));
    if (r) begin
      check({nm, ".t2_writeA"}, 256'(t2_wa), 256'(core_t2_writeA));
      check({nm, ".t2_addrA"},  256'(t2_aa), 256'(core_t2_addrA));
      check({nm, ".t2_dinA"},   256'(t2_da), 256'(core_t2_dinA));
      check({nm, ".t2_bwA"},    256'(t2_bw), 256'(core_t2_bwA));
      check({nm, ".t2_readB"},  256'(t2_rb), 256'(core_t2_readB));
      check({nm, ".t3_writeA"}, 256'(t3_wa), 256'(core_t3_writeA));
      check({nm, ".t3_addrA"},  256'(t3_aa), 256'(core_t3_addrA));
      check({nm, ".t3_dinA"},   256'(t3_da), 256'(core_t3_dinA));
      check({nm, ".t3_bwA"},    256'(t3_bw), 256'(core_t3_bwA));
      check({nm, ".t3_readB"},  256'(t3_rb), 256'(core_t3_readB));
    end else begin
      for (int q = 0; q < 2; q++) begin
        int row;
        bit we;
        row = 2 * (k - 1) + q;
        we  = (k >= 1) && (k <= (n + 1) / 2) && (row < n);
        check($sformatf("%s.t2_writeA[%0d]", nm, q), 256'(t2_wa[q]), 256'(we));
        check($sformatf("%s.t3_writeA[%0d]", nm, q), 256'(t3_wa[q]), 256'(we));
        if (we) begin
          check($sformatf("%s.t2_addrA[%0d]", nm, q), 256'(t2_aa[BV*q +: BV]), 256'(row));
          check($sformatf("%s.t3_addrA[%0d]", nm, q), 256'(t3_aa[BV*q +: BV]), 256'(row));
        end
      end
      check({nm, ".t2_dinA"},  256'(t2_da), 256'({T2V, T2V}));
      check({nm, ".t2_bwA"},   256'(t2_bw), 256'({(2*SW){1'b1}}));
      check({nm, ".t2_readB"}, 256'(t2_rb), 256'(0));
      check({nm, ".t3_dinA"},  256'(t3_da), 256'({T3V, T3V}));
      check({nm, ".t3_bwA"},   256'(t3_bw), 256'({(2*CW){1'b1}}));
      check({nm, ".t3_readB"}, 256'(t3_rb), 256'(0));
    end
    check({nm, ".t2_addrB"}, 256'(t2_ab), 256'(core_t2_addrB));
    check({nm, ".t3_addrB"}, 256'(t3_ab), 256'(core_t3_addrB));
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    cmp_inst("n8", 8, k8, e8, a_t2_wa, a_t2_aa, a_t2_da, a_t2_bw, a_t2_rb, a_t2_ab,
             a_t3_wa, a_t3_aa, a_t3_da, a_t3_bw, a_t3_rb, a_t3_ab, a_ready, a_err);
    cmp_inst("n7", 7, k7, e7, b_t2_wa, b_t2_aa, b_t2_da, b_t2_bw, b_t2_rb, b_t2_ab,
             b_t3_wa, b_t3_aa, b_t3_da, b_t3_bw, b_t3_rb, b_t3_ab, b_ready, b_err);
  end

  task automatic idle_core();
    core_t2_writeA = '0; core_t2_addrA = '0; core_t2_dinA = '0; core_t2_bwA = '0;
    core_t2_readB  = '0; core_t2_addrB = '0;
    core_t3_writeA = '0; core_t3_addrA = '0; core_t3_dinA = '0; core_t3_bwA = '0;
    core_t3_readB  = '0; core_t3_addrB = '0;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_core(input bit allow_acc);
    core_t2_addrA  = 6'($urandom);
    core_t2_addrB  = 6'($urandom);
    core_t3_addrA  = 6'($urandom);
    core_t3_addrB  = 6'($urandom);
    core_t2_dinA   = 20'($urandom);
    core_t2_bwA    = 20'($urandom);
    core_t3_dinA   = 142'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    core_t3_bwA    = 142'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    core_t2_writeA = allow_acc ? 2'($urandom) : 2'b00;
    core_t2_readB  = allow_acc ? 2'($urandom) : 2'b00;
    core_t3_writeA = allow_acc ? 2'($urandom) : 2'b00;
    core_t3_readB  = allow_acc ? 2'($urandom) : 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    reinit = 1'b0;
    idle_core();
    repeat (2) @(negedge clk);
    check("rst.ready", 256'(a_ready), 256'(0));
    check("rst.t2_writeA", 256'(a_t2_wa), 256'(0));
    rst = 1'b0;

    // edge 1: first pair (0,1); core write at edge 2 must not get through
    edge_step();
    core_t3_writeA = 2'b10;
    @(negedge clk);
    check("e1.t2_writeA", 256'(a_t2_wa), 256'(2'b11));
    check("e1.t2_addrA", 256'(a_t2_aa), 256'({3'd1, 3'd0}));
    check("e1.t3_writeA_init_wins", 256'(a_t3_wa), 256'(2'b11));
    edge_step();
    core_t3_writeA = 2'b00;
    @(negedge clk);
    check("e2.init_err8", 256'(a_err), 256'(1));
    check("e2.init_err7", 256'(b_err), 256'(1));
    edge_step();
    edge_step();
    @(negedge clk);
    check("e4.n7_writeA", 256'(b_t2_wa), 256'(2'b01));
    check("e4.n7_addr0", 256'(b_t2_aa[2:0]), 256'(3'd6));
    check("e4.n8_addrA", 256'(a_t2_aa), 256'({3'd7, 3'd6}));
    edge_step();
    edge_step();
    @(negedge clk);
    check("e6.ready8", 256'(a_ready), 256'(0));
    check("e6.ready7", 256'(b_ready), 256'(0));
    edge_step();
    @(negedge clk);
    check("e7.ready8", 256'(a_ready), 256'(1));
    check("e7.ready7", 256'(b_ready), 256'(1));
    check("e7.err_holds", 256'(a_err), 256'(1));

    // zero-latency passthrough of a core read
    core_t2_readB = 2'b01;
    core_t2_addrB = 6'd5;
    #1;
    check("pass.t2_readB", 256'(a_t2_rb), 256'(2'b01));
    check("pass.t2_addrB", 256'(a_t2_addrB_lo()), 256'(3'd5));
    edge_step();
    idle_core();

    // accepted reinit, then an ignored one while writing row pair 2
    reinit = 1'b1;
    edge_step();
    reinit = 1'b0;
    @(negedge clk);
    check("reinit.ready", 256'(a_ready), 256'(0));
    check("reinit.err_clr", 256'(a_err), 256'(0));
    for (int e = 1; e <= 7; e++) begin
      edge_step();
      reinit = (e == 2);
      @(negedge clk);
      if (e == 6) check("replay.e6_ready", 256'(a_ready), 256'(0));
      if (e == 7) check("replay.e7_ready", 256'(a_ready), 256'(1));
    end
    check("replay.err", 256'(a_err), 256'(0));

    // reset in the middle of init aborts at once and restarts from row 0
    reinit = 1'b1;
    edge_step();
    reinit = 1'b0;
    repeat (4) edge_step();
    #1;
    rst = 1'b1;
    #1;
    check("midrst.t2_writeA", 256'(a_t2_wa), 256'(0));
    check("midrst.t3_writeA", 256'(a_t3_wa), 256'(0));
    check("midrst.ready", 256'(a_ready), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    edge_step();
    #1;
    check("restart.t2_writeA", 256'(a_t2_wa), 256'(2'b11));
    check("restart.t2_addrA", 256'(a_t2_aa), 256'({3'd1, 3'd0}));

    // randomized traffic, occasional reinit and reset
    for (int c = 0; c < 800; c++) begin
      edge_step();
      rand_core((m_rdy(8, k8) && m_rdy(7, k7)) || ($urandom_range(31) == 0));
      reinit = ($urandom_range(15) == 0);
      if ($urandom_range(199) == 0) begin
        rst = 1'b1;
        edge_step();
        rst = 1'b0;
      end
    end

    edge_step();
    idle_core();
    reinit = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  function automatic logic [BV-1:0] a_t2_addrB_lo();
    return a_t2_ab[BV-1:0];
  endfunction

endmodule
